// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared types and sizes for the matmul4x4 stream controller.
//   N      : matrix dimension (array is N x N)
//   DW/RW  : signed operand / result element widths
//   elem_t / acc_t : signed operand / result element
//   mat_t / res_t  : [N][N] unpacked operand / result matrices
//   state_t        : controller FSM states
// -----------------------------------------------------------------------------
package matmul_pkg;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int RW    = 16;
  localparam int NN    = N * N;
  localparam int CNT_W = $clog2(2 * NN);  // operand element counter (A then B)
  localparam int RD_W  = $clog2(NN);      // result read counter
  localparam int COL_W = $clog2(N);       // column field inside a flat index

  typedef logic signed [DW-1:0] elem_t;
  typedef logic signed [RW-1:0] acc_t;
  typedef elem_t mat_t [N][N];
  typedef acc_t  res_t [N][N];

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;
endpackage

// File: rtl/matmul_stream_ctrl_drain.sv
// -----------------------------------------------------------------------------
// matmul_result_drain
// Captures the array result matrix and serialises it row-major on a
// valid/ready stream.
//   clk, rst    : clock, synchronous active-high reset
//   i_capture   : load i_ans into the buffer and restart the read pointer
//   i_active    : controller is in DRAIN; drives out_valid
//   i_ans       : result matrix from matmul4x4
//   out_*       : result stream (valid/ready)
//   o_done      : handshake of the final element this cycle
// Handshake: a beat transfers on a rising edge where out_valid & out_ready;
// out_data/out_last hold steady while out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module matmul_result_drain
  import matmul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_capture,
  input  logic i_active,
  input  res_t i_ans,
  output logic out_valid,
  input  logic out_ready,
  output acc_t out_data,
  output logic out_last,
  output logic o_done
);
  res_t            r_buf;
  logic [RD_W-1:0] r_rd_cnt;
  logic            w_fire;

  assign out_valid = i_active;
  assign out_data  = r_buf[r_rd_cnt[RD_W-1:COL_W]][r_rd_cnt[COL_W-1:0]];
  assign out_last  = i_active && (r_rd_cnt == RD_W'(NN - 1));
  assign w_fire    = out_valid && out_ready;
  assign o_done    = w_fire && out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          r_buf[i][j] <= '0;
      r_rd_cnt <= '0;
    end else if (i_capture) begin
      r_buf    <= i_ans;
      r_rd_cnt <= '0;
    end else if (w_fire) begin
      // Wraps to 0 after the last element, ready for the next job.
      r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/matmul_stream_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_stream_ctrl
// Stream-side controller for matmul4x4: loads A then B (row-major) from an
// element stream, holds the array out of reset for COMPUTE_CYCLES cycles,
// captures the result and streams it back row-major.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : operand stream
//   mm_a, mm_b, mm_rst, mm_ans    : matmul4x4 connection
//   out_valid/out_ready/out_data/out_last : result stream
//   busy                  : high in COMPUTE or DRAIN
//   dbg_state             : current FSM state
// Handshake (both streams): a transfer happens on a rising edge where valid
// and ready are both high; the producer holds data until that edge.
// -----------------------------------------------------------------------------
module matmul_stream_ctrl
  import matmul_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  elem_t  in_data,
  output mat_t   mm_a,
  output mat_t   mm_b,
  output logic   mm_rst,
  input  res_t   mm_ans,
  output logic   out_valid,
  input  logic   out_ready,
  output acc_t   out_data,
  output logic   out_last,
  output logic   busy,
  output state_t dbg_state
);
  localparam int TMR_W = $clog2(COMPUTE_CYCLES + 1);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_elem_cnt;
  logic [TMR_W-1:0] r_timer;
  mat_t             r_a, r_b;

  logic             w_in_fire, w_last_in, w_timer_done, w_drain_done, w_sel_b;
  logic [RD_W-1:0]  w_idx;

  assign w_in_fire    = in_valid && in_ready;
  assign w_last_in    = w_in_fire && (r_elem_cnt == CNT_W'(2 * NN - 1));
  assign w_timer_done = (r_state == COMPUTE) && (r_timer == TMR_W'(COMPUTE_CYCLES - 1));
  // First N*N elements land in A, the next N*N in B; w_idx is the flat
  // row-major position inside the selected matrix.
  assign w_sel_b      = (r_elem_cnt >= CNT_W'(NN));
  assign w_idx        = w_sel_b ? RD_W'(r_elem_cnt - CNT_W'(NN)) : RD_W'(r_elem_cnt);

  assign mm_a      = r_a;
  assign mm_b      = r_b;
  assign dbg_state = r_state;

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    mm_rst       = 1'b1;
    busy         = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (w_last_in) w_next_state = COMPUTE;
      end
      COMPUTE: begin
        mm_rst = 1'b0;
        busy   = 1'b1;
        if (w_timer_done) w_next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_drain_done) w_next_state = LOAD;
      end
      default: w_next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOAD;
      r_elem_cnt <= '0;
      r_timer    <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
    end else begin
      r_state <= w_next_state;

      if (w_in_fire) begin
        r_elem_cnt <= w_last_in ? '0 : r_elem_cnt + 1'b1;
        if (w_sel_b) r_b[w_idx[RD_W-1:COL_W]][w_idx[COL_W-1:0]] <= in_data;
        else         r_a[w_idx[RD_W-1:COL_W]][w_idx[COL_W-1:0]] <= in_data;
      end

      if (r_state == COMPUTE && !w_timer_done) r_timer <= r_timer + 1'b1;
      else                                     r_timer <= '0;
    end
  end

  matmul_result_drain u_drain (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_timer_done),
    .i_active  (r_state == DRAIN),
    .i_ans     (mm_ans),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .o_done    (w_drain_done)
  );
endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_stream_ctrl
// Self-checking bench for matmul_stream_ctrl with a behavioural matmul4x4
// model (result appears after the array latency while mm_rst is low) and a
// golden product computed from the stimulus itself.
// -----------------------------------------------------------------------------
module tb_matmul_stream_ctrl;
  import matmul_pkg::*;

  localparam int CC = 10;

  // ---------------- clock / reset / DUT ----------------
  logic   clk = 1'b0;
  logic   rst;
  logic   in_valid, in_ready;
  elem_t  in_data;
  mat_t   mm_a, mm_b;
  logic   mm_rst;
  res_t   mm_ans;
  logic   out_valid, out_ready;
  acc_t   out_data;
  logic   out_last, busy;
  state_t dbg_state;

  always #5 clk = ~clk;

  matmul_stream_ctrl #(.COMPUTE_CYCLES(CC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_rst    (mm_rst),
    .mm_ans    (mm_ans),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- matmul4x4 environment model ----------------
  int low_cnt = 0;
  always @(posedge clk) low_cnt <= (mm_rst !== 1'b0) ? 0 : low_cnt + 1;

  function automatic res_t env_mul(input mat_t a, input mat_t b);
    res_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(a[i][k]) * int'(b[k][j]);
        r[i][j] = acc_t'(s);
      end
    return r;
  endfunction

  // Result is valid from the (3N-2)-th consecutive cycle with mm_rst low.
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mm_ans[i][j] = '0;
    if (mm_rst === 1'b0 && low_cnt >= 3 * N - 3) mm_ans = env_mul(mm_a, mm_b);
  end

  // ---------------- scoreboard ----------------
  logic [RW:0] exp_q[$];  // {last, data}

  task automatic push_golden(input int a[2*NN], input int b[2*NN]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        logic [RW-1:0] v;
        for (int k = 0; k < N; k++) s += a[i*N+k] * b[k*N+j];
        v = s[RW-1:0];
        exp_q.push_back({(i == N-1 && j == N-1), v});
      end
  endtask

  // ---------------- out_ready driver ----------------
  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor (sampled on the falling edge) ----------------
  bit          stall_pend = 1'b0;
  logic [RW:0] stall_val;
  bit          last_fired = 1'b0;
  int          low_run    = 0;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      stall_pend = 1'b0;
      last_fired = 1'b0;
      low_run    = 0;
    end else begin
      if (last_fired) check("in_ready_after_last", {30'd0, in_ready, out_valid}, 32'h2);
      last_fired = 1'b0;

      if (stall_pend && out_valid) check("stall_hold", {15'd0, out_last, out_data}, {15'd0, stall_val});
      stall_pend = out_valid && !out_ready;
      stall_val  = {out_last, out_data};

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else check("beat", {15'd0, out_last, out_data}, {15'd0, exp_q.pop_front()});
        last_fired = out_last;
      end

      if (busy && in_valid) check("in_ready_busy", {31'd0, in_ready}, 32'd0);

      if (mm_rst === 1'b0) low_run++;
      else if (low_run != 0) begin
        check("mm_rst_low_len", low_run, CC);
        low_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_elem(input int v, input bit gaps);
    bit rdy;
    bit done = 1'b0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = elem_t'(v);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      done = rdy;
    end
    if (!done) check("in_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mm_a[i][j] !== '0 || mm_b[i][j] !== '0) bad++;
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, LOAD});
    check({tag, "_flags"}, {27'd0, in_ready, mm_rst, out_valid, out_last, busy}, 32'b11000);
    check({tag, "_mats_zero"}, bad, 0);
  endtask

  task automatic run_job(input int a[2*NN], input int b[2*NN], input bit gaps, input bit junk);
    int  lat = 0;
    int  bad = 0;
    bit  done = 1'b0;
    push_golden(a, b);
    for (int i = 0; i < NN; i++) send_elem(a[i], gaps);
    for (int i = 0; i < NN; i++) send_elem(b[i], gaps);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = elem_t'($urandom_range(0, 255));
    end
    // Edges from the last input handshake edge to the edge raising out_valid.
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (junk) in_data = elem_t'($urandom_range(0, 255));
    end
    check("latency", lat, CC);
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = out_valid && out_ready && out_last;
    end
    in_valid = 1'b0;
    if (!done) check("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 0);
    for (int i = 0; i < NN; i++) begin
      if (mm_a[i/N][i%N] !== elem_t'(a[i])) bad++;
      if (mm_b[i/N][i%N] !== elem_t'(b[i])) bad++;
    end
    check("mm_ab_hold", bad, 0);
  endtask

  function automatic int rnd_elem();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int a[2*NN];
    int b[2*NN];
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Identity A -> results equal B.
    b = '{1, 2, 3, 4, 9, 10, 11, 12, 17, 14, 19, 20, 25, 26, 27, 24,
          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 2*NN; i++) a[i] = (i < NN && i / N == i % N) ? 1 : 0;
    run_job(a, b, 1'b0, 1'b0);

    // All -1 times all 2 -> every element -8.
    for (int i = 0; i < 2*NN; i++) begin a[i] = -1; b[i] = 2; end
    run_job(a, b, 1'b0, 1'b0);

    // Random operands, input gaps, random downstream stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 2*NN; i++) begin a[i] = rnd_elem(); b[i] = rnd_elem(); end
      run_job(a, b, 1'b1, 1'b0);
    end

    // Junk held on the input while busy.
    for (int i = 0; i < 2*NN; i++) begin a[i] = rnd_elem(); b[i] = rnd_elem(); end
    run_job(a, b, 1'b0, 1'b1);

    // Abort mid-load, then a clean job.
    for (int i = 0; i < 20; i++) send_elem(rnd_elem(), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("abort");
    for (int i = 0; i < 2*NN; i++) begin a[i] = rnd_elem(); b[i] = rnd_elem(); end
    run_job(a, b, 1'b0, 1'b0);

    // Back-to-back jobs with extreme values.
    for (int i = 0; i < 2*NN; i++) begin a[i] = -128; b[i] = -128; end
    run_job(a, b, 1'b0, 1'b0);
    for (int i = 0; i < 2*NN; i++) begin a[i] = rnd_elem(); b[i] = 127; end
    run_job(a, b, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
